// File: rtl/bch_pkg.sv
// rtl/bch_pkg.sv - BCH(15,7) code constants, decoder states and GF(16) arithmetic
package bch_pkg;

  localparam int BCH_N = 15;
  localparam int BCH_K = 7;
  localparam int BCH_T = 2;
  localparam logic [8:0] BCH_GEN = 9'h1D1;
  localparam logic [4:0] GF_POLY = 5'h13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYND,
    ST_KEY,
    ST_CHIEN,
    ST_DIV,
    ST_DONE
  } bch_dec_state_e;

  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] aa;
    p  = 4'h0;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[2:0], 1'b0} ^ (aa[3] ? GF_POLY[3:0] : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [3:0] gf16_sq(input logic [3:0] a);
    return gf16_mul(a, a);
  endfunction

  // a^-1 = a^14 = a^8 * a^4 * a^2; maps 0 to 0
  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf16_sq(a);
    a4 = gf16_sq(a2);
    a8 = gf16_sq(a4);
    return gf16_mul(gf16_mul(a8, a4), a2);
  endfunction

  function automatic logic [3:0] gf16_eval(input logic [BCH_N-1:0] w, input logic [3:0] a);
    logic [3:0] s;
    s = 4'h0;
    for (int i = BCH_N - 1; i >= 0; i--) s = gf16_mul(s, a) ^ {3'b000, w[i]};
    return s;
  endfunction

endpackage

// File: rtl/bch_decoder_if.sv
// rtl/bch_decoder_if.sv - received-word input and decoded-result output handshake bundle
interface bch_decoder_if;
  import bch_pkg::*;

  logic                        in_valid;
  logic                        in_ready;
  logic [BCH_N-1:0]            in_codeword;
  logic                        out_valid;
  logic                        out_ready;
  logic [BCH_N-1:0]            out_codeword;
  logic [BCH_K-1:0]            out_message;
  logic [$clog2(BCH_T+1)-1:0]  out_nerr;
  logic                        out_fail;

  modport master (
    output in_valid, in_codeword, out_ready,
    input  in_ready, out_valid, out_codeword, out_message, out_nerr, out_fail
  );

  modport slave (
    input  in_valid, in_codeword, out_ready,
    output in_ready, out_valid, out_codeword, out_message, out_nerr, out_fail
  );
endinterface

// File: rtl/bch_chien_search.sv
// rtl/bch_chien_search.sv - serial Chien search of sigma(x) = 1 + s1*x + s2*x^2 at alpha^-k, k = 0..14
module bch_chien_search
  import bch_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [3:0] sigma1,
  input  logic [3:0] sigma2,
  output logic       root,
  output logic [3:0] pos,
  output logic       done
);

  logic       active;
  logic [3:0] t1, t2, k;

  // t1 = sigma1*alpha^-k, t2 = sigma2*alpha^-2k; alpha^-1 = 4'h9, alpha^-2 = 4'hD
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active <= 1'b0;
      t1     <= 4'h0;
      t2     <= 4'h0;
      k      <= 4'h0;
    end else if (start) begin
      active <= 1'b1;
      t1     <= sigma1;
      t2     <= sigma2;
      k      <= 4'h0;
    end else if (active) begin
      t1 <= gf16_mul(t1, 4'h9);
      t2 <= gf16_mul(t2, 4'hD);
      k  <= k + 4'h1;
      if (k == 4'(BCH_N - 1)) active <= 1'b0;
    end
  end

  assign root = active && ((4'h1 ^ t1 ^ t2) == 4'h0);
  assign pos  = k;
  assign done = active && (k == 4'(BCH_N - 1));

endmodule

// File: rtl/bch_decoder.sv
// rtl/bch_decoder.sv - BCH(15,7) t=2 decoder: syndromes, key equation, Chien search, division by g(x)
// Define BCH_DEC_PARALLEL_SYND_EN for a single-cycle syndrome stage.
module bch_decoder
  import bch_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  bch_decoder_if.slave bus
);

  bch_dec_state_e   state, state_nx;
  logic [BCH_N-1:0] rx, cw, rem, rem_nx, chien_word, out_cw;
  logic [BCH_K-1:0] out_msg;
  logic [3:0]       s1, s3, cnt, s1_cube, sigma2, pos;
  logic [1:0]       deg, nroot, nerr, roots_total, out_ne;
  logic [5:0]       quo;
  logic             fail, out_fl, q_bit, chien_ok, chien_start, root, chien_done;
  logic             in_ready_c, out_valid_c;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    chien_start = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nx = ST_SYND;
      end
`ifdef BCH_DEC_PARALLEL_SYND_EN
      ST_SYND:  state_nx = ST_KEY;
`else
      ST_SYND:  if (cnt == 4'(BCH_N - 1)) state_nx = ST_KEY;
`endif
      ST_KEY: begin
        chien_start = (s1 != 4'h0);
        state_nx    = (s1 != 4'h0) ? ST_CHIEN : ST_DIV;
      end
      ST_CHIEN: if (chien_done) state_nx = ST_DIV;
      ST_DIV:   if (cnt == 4'(BCH_K - 1)) state_nx = ST_DONE;
      ST_DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nx = ST_IDLE;
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign s1_cube = gf16_mul(gf16_sq(s1), s1);
  // Zero when S3 = S1^3, which degenerates sigma to the single-error locator
  assign sigma2  = gf16_mul(s3 ^ s1_cube, gf16_inv(s1));

  always_comb begin
    chien_word = cw;
    if (root) chien_word[pos] = ~cw[pos];
  end
  assign roots_total = nroot + {1'b0, root};
  assign chien_ok    = (roots_total == deg);

  assign q_bit  = rem[BCH_N-1];
  assign rem_nx = (rem ^ (q_bit ? {BCH_GEN, 6'b000000} : '0)) << 1;

  bch_chien_search u_chien (
    .clk    (clk),
    .rstn   (rstn),
    .start  (chien_start),
    .sigma1 (s1),
    .sigma2 (sigma2),
    .root   (root),
    .pos    (pos),
    .done   (chien_done)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx <= '0; cw <= '0; rem <= '0; quo <= '0;
      s1 <= 4'h0; s3 <= 4'h0; cnt <= 4'h0;
      deg <= 2'd0; nroot <= 2'd0; nerr <= 2'd0; fail <= 1'b0;
      out_cw <= '0; out_msg <= '0; out_ne <= 2'd0; out_fl <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.in_valid) begin
          rx <= bus.in_codeword; cw <= bus.in_codeword;
          s1 <= 4'h0; s3 <= 4'h0; cnt <= 4'h0;
          nroot <= 2'd0; nerr <= 2'd0; fail <= 1'b0;
        end
`ifdef BCH_DEC_PARALLEL_SYND_EN
        ST_SYND: begin
          s1 <= gf16_eval(rx, 4'h2);
          s3 <= gf16_eval(rx, 4'h8);
        end
`else
        // Horner: S1 over alpha (4'h2), S3 over alpha^3 (4'h8), MSB first
        ST_SYND: begin
          s1  <= gf16_mul(s1, 4'h2) ^ {3'b000, rx[4'd14 - cnt]};
          s3  <= gf16_mul(s3, 4'h8) ^ {3'b000, rx[4'd14 - cnt]};
          cnt <= (cnt == 4'(BCH_N - 1)) ? 4'h0 : cnt + 4'h1;
        end
`endif
        ST_KEY: begin
          deg   <= (s3 == s1_cube) ? 2'd1 : 2'd2;
          nroot <= 2'd0;
          cnt   <= 4'h0;
          rem   <= cw;
          if (s1 == 4'h0) fail <= (s3 != 4'h0);
        end
        ST_CHIEN: begin
          nroot <= roots_total;
          cw    <= chien_word;
          if (chien_done) begin
            cnt <= 4'h0;
            if (chien_ok) begin
              rem  <= chien_word;
              nerr <= roots_total;
            end else begin
              cw   <= rx;
              rem  <= rx;
              nerr <= 2'd0;
              fail <= 1'b1;
            end
          end
        end
        ST_DIV: begin
          rem <= rem_nx;
          quo <= {quo[4:0], q_bit};
          cnt <= cnt + 4'h1;
          if (cnt == 4'(BCH_K - 1)) begin
            out_cw  <= cw;
            out_msg <= {quo, q_bit};
            out_ne  <= nerr;
            out_fl  <= fail | (|rem_nx[BCH_N-1:BCH_K]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = out_valid_c;
  assign bus.out_codeword = out_cw;
  assign bus.out_message  = out_msg;
  assign bus.out_nerr     = out_ne;
  assign bus.out_fail     = out_fl;

endmodule

// File: tb/tb_bch_decoder.sv
// tb/tb_bch_decoder.sv - self-checking bench for bch_decoder against a nearest-codeword search model
module tb_bch_decoder;

`ifdef BCH_DEC_PARALLEL_SYND_EN
  localparam int LAT_FULL = 24;
  localparam int LAT_ZERO = 9;
`else
  localparam int LAT_FULL = 38;
  localparam int LAT_ZERO = 23;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  bch_decoder_if bus();

  bch_decoder dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  function automatic logic [14:0] enc(input logic [6:0] m);
    logic [14:0] r;
    r = 15'h0;
    for (int i = 0; i < 7; i++) if (m[i]) r = r ^ (15'h01D1 << i);
    return r;
  endfunction

  // Bounded-distance decoding by exhaustive search over all 128 codewords
  function automatic void ref_decode(input logic [14:0] r, output logic [14:0] cw,
                                     output logic [6:0] msg, output logic [1:0] ne,
                                     output logic fl);
    logic [14:0] d;
    logic [6:0]  quo;
    bit          found;
    found = 0; quo = 7'h0; cw = r; msg = 7'h0; ne = 2'd0;
    for (int m = 0; m < 128; m++) begin
      d = r ^ enc(7'(m));
      if (d < 15'd256) quo = 7'(m);
      if (!found && $countones(d) <= 2) begin
        found = 1; cw = enc(7'(m)); msg = 7'(m); ne = 2'($countones(d));
      end
    end
    fl = !found;
    if (!found) msg = quo;
  endfunction

  task automatic start_word(input logic [14:0] w);
    int n;
    n = 0;
    bus.in_codeword = w;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (bus.out_valid !== 1'b1) lat = -1;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.out_codeword, bus.out_message, bus.out_nerr, bus.out_fail}
        !== {1'b1, 1'b0, 15'h0, 7'h0, 2'd0, 1'b0}) begin
      $display("FAIL reset_state: ready=%b valid=%b cw=%h msg=%h nerr=%0d fail=%b, required 1 0 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_codeword, bus.out_message, bus.out_nerr, bus.out_fail);
      n_bad++;
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      $display("FAIL reset_release: ready=%b valid=%b, required 1 0", bus.in_ready, bus.out_valid);
      n_bad++;
    end
  endtask

  task automatic test_directed();
    logic [14:0] words [4] = '{15'h01D1, 15'h01D0, 15'h41D0, 15'h58CF ^ 15'h1208};
    logic [14:0] e_cw [3]  = '{15'h01D1, 15'h01D1, 15'h01D1};
    logic [1:0]  e_ne [3]  = '{2'd0, 2'd1, 2'd2};
    int          e_lat [3] = '{LAT_ZERO, LAT_FULL, LAT_FULL};
    logic [14:0] m_cw;
    logic [6:0]  m_msg;
    logic [1:0]  m_ne;
    logic        m_fl;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      start_word(words[i]);
      wait_result(lat);
      if (i < 3) begin
        n_cmp++;
        if (bus.out_codeword !== e_cw[i] || bus.out_message !== 7'h01 ||
            bus.out_nerr !== e_ne[i] || bus.out_fail !== 1'b0) begin
          $display("FAIL directed_%0d: cw=%h msg=%h nerr=%0d fail=%b, required %h 01 %0d 0",
                   i, bus.out_codeword, bus.out_message, bus.out_nerr, bus.out_fail, e_cw[i], e_ne[i]);
          n_bad++;
        end
        n_cmp++;
        if (lat !== e_lat[i]) begin
          $display("FAIL directed_lat_%0d: latency %0d, required %0d", i, lat, e_lat[i]);
          n_bad++;
        end
      end else begin
        ref_decode(words[i], m_cw, m_msg, m_ne, m_fl);
        n_cmp++;
        if (bus.out_codeword !== m_cw || bus.out_message !== m_msg ||
            bus.out_nerr !== m_ne || bus.out_fail !== m_fl || m_cw == 15'h58CF) begin
          $display("FAIL directed_3err: cw=%h msg=%h nerr=%0d fail=%b, required %h %h %0d %b",
                   bus.out_codeword, bus.out_message, bus.out_nerr, bus.out_fail, m_cw, m_msg, m_ne, m_fl);
          n_bad++;
        end
      end
      release_result();
    end
  endtask

  task automatic test_random();
    logic [14:0] w, m_cw;
    logic [6:0]  m_msg;
    logic [1:0]  m_ne;
    logic        m_fl;
    int          lat, b1, b2, kind;
    bit          lat_ok;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      w  = enc(7'($urandom_range(0, 127)));
      b1 = $urandom_range(0, 14);
      b2 = (b1 + $urandom_range(1, 14)) % 15;
      if (kind >= 1) w[b1] = ~w[b1];
      if (kind >= 2) w[b2] = ~w[b2];
      if (kind == 3) w = 15'($urandom);
      ref_decode(w, m_cw, m_msg, m_ne, m_fl);
      start_word(w);
      wait_result(lat);
      n_cmp++;
      if (bus.out_codeword !== m_cw || bus.out_message !== m_msg ||
          bus.out_nerr !== m_ne || bus.out_fail !== m_fl) begin
        $display("FAIL random_%0d in=%h: cw=%h msg=%h nerr=%0d fail=%b, required %h %h %0d %b",
                 i, w, bus.out_codeword, bus.out_message, bus.out_nerr, bus.out_fail, m_cw, m_msg, m_ne, m_fl);
        n_bad++;
      end
      lat_ok = m_fl ? (lat == LAT_ZERO || lat == LAT_FULL)
                    : (lat == ((m_ne == 2'd0) ? LAT_ZERO : LAT_FULL));
      n_cmp++;
      if (!lat_ok) begin
        $display("FAIL random_lat_%0d in=%h: latency %0d, required %0d", i, w, lat,
                 (m_ne == 2'd0) ? LAT_ZERO : LAT_FULL);
        n_bad++;
      end
      release_result();
    end
  endtask

  task automatic test_sweep3();
    logic [14:0] w, m_cw;
    logic [6:0]  m_msg;
    logic [1:0]  m_ne;
    logic        m_fl;
    int          lat;
    for (int a = 0; a < 15; a++)
      for (int b = a + 1; b < 15; b++)
        for (int c = b + 1; c < 15; c++) begin
          w = 15'h58CF ^ (15'h1 << a) ^ (15'h1 << b) ^ (15'h1 << c);
          ref_decode(w, m_cw, m_msg, m_ne, m_fl);
          start_word(w);
          wait_result(lat);
          n_cmp++;
          if (lat < 0 || bus.out_codeword !== m_cw || bus.out_message !== m_msg ||
              bus.out_nerr !== m_ne || bus.out_fail !== m_fl) begin
            $display("FAIL sweep3 in=%h lat=%0d: cw=%h msg=%h nerr=%0d fail=%b, required %h %h %0d %b",
                     w, lat, bus.out_codeword, bus.out_message, bus.out_nerr, bus.out_fail,
                     m_cw, m_msg, m_ne, m_fl);
            n_bad++;
          end
          release_result();
        end
  endtask

  task automatic test_backpressure();
    logic [14:0] m_cw;
    logic [6:0]  m_msg;
    logic [1:0]  m_ne;
    logic        m_fl;
    int          lat;
    bit          bad;
    ref_decode(15'h58DF, m_cw, m_msg, m_ne, m_fl);
    start_word(15'h58DF);
    wait_result(lat);
    bus.in_codeword = 15'h1234;
    bus.in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_codeword !== m_cw ||
          bus.out_message !== m_msg || bus.out_nerr !== m_ne || bus.out_fail !== m_fl) bad = 1;
    end
    n_cmp++;
    if (bad || lat != LAT_FULL) begin
      $display("FAIL backpressure_hold: valid=%b ready=%b cw=%h msg=%h lat=%0d, required 1 0 %h %h %0d",
               bus.out_valid, bus.in_ready, bus.out_codeword, bus.out_message, lat, m_cw, m_msg, LAT_FULL);
      n_bad++;
    end
    bus.in_valid = 1'b0;
    release_result();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      $display("FAIL backpressure_release: valid=%b ready=%b, required 0 1", bus.out_valid, bus.in_ready);
      n_bad++;
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      $display("FAIL backpressure_no_capture: ready=%b valid=%b, required 1 0", bus.in_ready, bus.out_valid);
      n_bad++;
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit bad;
    start_word(15'h01D0);
    repeat (LAT_FULL - 15) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_codeword !== 15'h0 ||
        bus.out_message !== 7'h0 || bus.out_nerr !== 2'd0 || bus.out_fail !== 1'b0) begin
      $display("FAIL reset_mid_immediate: valid=%b ready=%b cw=%h msg=%h, required 0 1 0 0",
               bus.out_valid, bus.in_ready, bus.out_codeword, bus.out_message);
      n_bad++;
    end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    bad = 0;
    for (int i = 0; i < LAT_FULL + 5; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad = 1;
    end
    n_cmp++;
    if (bad) begin
      $display("FAIL reset_mid_dropped: valid=%b ready=%b, required 0 1", bus.out_valid, bus.in_ready);
      n_bad++;
    end
    start_word(15'h0000);
    wait_result(lat);
    n_cmp++;
    if (bus.out_codeword !== 15'h0 || bus.out_message !== 7'h00 || bus.out_nerr !== 2'd0 ||
        bus.out_fail !== 1'b0 || lat != LAT_ZERO) begin
      $display("FAIL reset_mid_next: cw=%h msg=%h nerr=%0d fail=%b lat=%0d, required 0 00 0 0 %0d",
               bus.out_codeword, bus.out_message, bus.out_nerr, bus.out_fail, lat, LAT_ZERO);
      n_bad++;
    end
    release_result();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_codeword = 15'h0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_sweep3();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
